grid_canvas_painter: RTL

- Parametrised drawing-canvas controller that sits between the mouse tracker and the VGA adapter.
- Maps a clicked mouse position to a GRID_W x GRID_H cell grid with iterative (division-free) cell location.
- Keeps a 1-bit-per-cell bitmap that the classifier reads through a registered port.
- Streams pixel plots to repaint single cells (paint/erase) or to clear the whole grid.

---
 rtl/grid_canvas_painter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/grid_canvas_painter.sv
// grid_canvas_painter: maps mouse clicks onto a cell grid, keeps a 1-bit-per-cell
// bitmap, and streams VGA pixel plots to repaint one cell or clear the whole grid.
module grid_canvas_painter #(
  parameter int          XMIN     = 88,
  parameter int          YMIN     = 37,
  parameter int          CELL_W   = 10,
  parameter int          CELL_H   = 14,
  parameter int          GRID_W   = 14,
  parameter int          GRID_H   = 14,
  parameter int          ADDR_W   = 8,
  parameter logic [14:0] FG_COLOR = 15'h7FFF,
  parameter logic [14:0] BG_COLOR = 15'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        mouse_x,
  input  logic [8:0]        mouse_y,
  input  logic              left_click,
  input  logic              right_click,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data,
  output logic [8:0]        vga_x,
  output logic [8:0]        vga_y,
  output logic [14:0]       vga_color,
  output logic              vga_plot,
  output logic              busy,
  output logic              grid_changed
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NCELL = GRID_W * GRID_H;

  localparam logic [8:0] XMIN9  = 9'(XMIN);
  localparam logic [8:0] YMIN9  = 9'(YMIN);
  localparam logic [8:0] CW9    = 9'(CELL_W);
  localparam logic [8:0] CH9    = 9'(CELL_H);
  localparam logic [8:0] XEND9  = 9'(XMIN + GRID_W * CELL_W);
  localparam logic [8:0] YEND9  = 9'(YMIN + GRID_H * CELL_H);
  localparam logic [8:0] CWM1   = 9'(CELL_W - 1);
  localparam logic [8:0] CHM1   = 9'(CELL_H - 1);
  localparam logic [8:0] FULLW1 = 9'(GRID_W * CELL_W - 1);
  localparam logic [8:0] FULLH1 = 9'(GRID_H * CELL_H - 1);
  localparam logic [ADDR_W:0] NCELL_A = (ADDR_W + 1)'(NCELL);

  // S_CLRZ zeroes the bitmap; S_PLOT serves both single-cell fills and full clears.
  typedef enum logic [2:0] {S_IDLE, S_LOCATE, S_CHECK, S_CLRZ, S_PLOT} state_t;

  state_t            state_q;
  logic [DEPTH-1:0]  bmp_q, bmp_d;
  logic [8:0]        dx_q, dy_q;
  logic [7:0]        col_q, row_q;
  logic              tgt_q;
  logic              clr_pend_q;
  logic [8:0]        base_x_q, base_y_q;
  logic [8:0]        lim_x_q, lim_y_q;
  logic [8:0]        cx_q, cy_q;
  logic [14:0]       color_q;
  logic              rd_data_q, vga_plot_q, grid_changed_q;
  logic [8:0]        vga_x_q, vga_y_q;
  logic [14:0]       vga_color_q;

  logic [ADDR_W-1:0] idx;
  logic              in_area;

  assign idx     = ADDR_W'(int'(row_q) * GRID_W + int'(col_q));
  assign in_area = (mouse_x >= XMIN9) && (mouse_x < XEND9) &&
                   (mouse_y >= YMIN9) && (mouse_y < YEND9);

  // Next bitmap: single-cell write in CHECK when the bit differs, full wipe on clear entry.
  always_comb begin
    bmp_d = bmp_q;
    if (state_q == S_CHECK && bmp_q[idx] != tgt_q) bmp_d[idx] = tgt_q;
    else if (state_q == S_CLRZ)                     bmp_d = '0;
  end

  // Bitmap storage and registered read port (reads see a write made in the same cycle).
  always_ff @(posedge clock) begin
    if (reset) begin
      bmp_q     <= '0;
      rd_data_q <= 1'b0;
    end else begin
      bmp_q     <= bmp_d;
      rd_data_q <= ({1'b0, rd_addr} < NCELL_A) ? bmp_d[rd_addr] : 1'b0;
    end
  end

  // Control FSM: locate the cell by repeated subtraction, then stream plots.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      dx_q           <= '0;
      dy_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      tgt_q          <= 1'b0;
      clr_pend_q     <= 1'b0;
      base_x_q       <= '0;
      base_y_q       <= '0;
      lim_x_q        <= '0;
      lim_y_q        <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      color_q        <= '0;
      vga_plot_q     <= 1'b0;
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      vga_color_q    <= '0;
      grid_changed_q <= 1'b0;
    end else begin
      vga_plot_q     <= 1'b0;
      grid_changed_q <= 1'b0;
      if (clear && state_q != S_IDLE) clr_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (clear || clr_pend_q) begin
            clr_pend_q <= 1'b0;
            state_q    <= S_CLRZ;
          end else if ((left_click || right_click) && in_area) begin
            dx_q    <= mouse_x - XMIN9;
            dy_q    <= mouse_y - YMIN9;
            col_q   <= '0;
            row_q   <= '0;
            tgt_q   <= left_click;
            state_q <= S_LOCATE;
          end
        end
        S_LOCATE: begin
          if (dx_q >= CW9) begin
            dx_q  <= dx_q - CW9;
            col_q <= col_q + 8'd1;
          end
          if (dy_q >= CH9) begin
            dy_q  <= dy_q - CH9;
            row_q <= row_q + 8'd1;
          end
          if (dx_q < CW9 && dy_q < CH9) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (bmp_q[idx] == tgt_q) begin
            state_q <= S_IDLE;
          end else begin
            grid_changed_q <= 1'b1;
            base_x_q       <= XMIN9 + 9'(int'(col_q) * CELL_W);
            base_y_q       <= YMIN9 + 9'(int'(row_q) * CELL_H);
            lim_x_q        <= CWM1;
            lim_y_q        <= CHM1;
            color_q        <= tgt_q ? FG_COLOR : BG_COLOR;
            cx_q           <= '0;
            cy_q           <= '0;
            state_q        <= S_PLOT;
          end
        end
        S_CLRZ: begin
          grid_changed_q <= 1'b1;
          base_x_q       <= XMIN9;
          base_y_q       <= YMIN9;
          lim_x_q        <= FULLW1;
          lim_y_q        <= FULLH1;
          color_q        <= BG_COLOR;
          cx_q           <= '0;
          cy_q           <= '0;
          state_q        <= S_PLOT;
        end
        S_PLOT: begin
          vga_plot_q  <= 1'b1;
          vga_x_q     <= base_x_q + cx_q;
          vga_y_q     <= base_y_q + cy_q;
          vga_color_q <= color_q;
          if (cx_q == lim_x_q) begin
            cx_q <= '0;
            if (cy_q == lim_y_q) state_q <= S_IDLE;
            else                 cy_q    <= cy_q + 9'd1;
          end else begin
            cx_q <= cx_q + 9'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_color    = vga_color_q;
  assign vga_plot     = vga_plot_q;
  assign grid_changed = grid_changed_q;
  assign busy         = (state_q != S_IDLE);

endmodule
